// File: rtl/roce_write_segmenter_64.sv
// roce_write_segmenter_64
//
// Splits one RDMA WRITE command and its 64-bit payload stream into
// PMTU-sized RC packets. For each packet it presents the BTH fields, the
// RETH fields (first packet only), the UDP length and the payload beats.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   s_cmd_*                  write command (length, remote address/key, QP, PSN, P_Key)
//   s_axis_*                 payload in (tkeep ignored, byte count comes from the command)
//   m_roce_bth_*             BTH header out, with m_udp_length
//   m_roce_reth_*            RETH header out (FIRST / ONLY packets)
//   m_roce_payload_axis_*    payload out; tuser flags a truncated packet
//   busy                     high whenever not idle
//   error_early_termination  one-cycle pulse: input tlast too early, or missing at the end
//   error_zero_length        one-cycle pulse: zero-length command rejected
//
// state   | meaning
// IDLE    | waiting for a command
// HDR     | header valids up, waiting for BTH / RETH handshakes
// PAYLOAD | forwarding payload beats of the current packet
// DRAIN   | command complete, discarding input until its tlast

module roce_write_segmenter_64 #(
    parameter int unsigned PMTU = 1024
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    input  logic [31:0] s_cmd_length,
    input  logic [63:0] s_cmd_v_addr,
    input  logic [31:0] s_cmd_r_key,
    input  logic [23:0] s_cmd_dest_qp,
    input  logic [23:0] s_cmd_psn,
    input  logic [15:0] s_cmd_p_key,

    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,

    output logic        m_roce_bth_valid,
    input  logic        m_roce_bth_ready,
    output logic [7:0]  m_roce_bth_op_code,
    output logic [15:0] m_roce_bth_p_key,
    output logic [23:0] m_roce_bth_psn,
    output logic [23:0] m_roce_bth_dest_qp,
    output logic        m_roce_bth_ack_req,

    output logic        m_roce_reth_valid,
    input  logic        m_roce_reth_ready,
    output logic [63:0] m_roce_reth_v_addr,
    output logic [31:0] m_roce_reth_r_key,
    output logic [31:0] m_roce_reth_length,

    output logic [15:0] m_udp_length,

    output logic [63:0] m_roce_payload_axis_tdata,
    output logic [7:0]  m_roce_payload_axis_tkeep,
    output logic        m_roce_payload_axis_tvalid,
    input  logic        m_roce_payload_axis_tready,
    output logic        m_roce_payload_axis_tlast,
    output logic        m_roce_payload_axis_tuser,

    output logic        busy,
    output logic        error_early_termination,
    output logic        error_zero_length
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DRAIN} state_t;

    localparam logic [31:0] PMTU_W = 32'(PMTU);

    state_t      state_q, state_d;
    logic [63:0] v_addr_q, v_addr_d;
    logic [31:0] r_key_q, r_key_d;
    logic [31:0] length_q, length_d;
    logic [31:0] remaining_q, remaining_d;
    logic [23:0] dest_qp_q, dest_qp_d;
    logic [23:0] psn_q, psn_d;
    logic [15:0] p_key_q, p_key_d;
    logic [15:0] udp_length_q, udp_length_d;
    logic [12:0] pkt_len_q, pkt_len_d;
    logic [12:0] pkt_left_q, pkt_left_d;
    logic [7:0]  op_code_q, op_code_d;
    logic        ack_req_q, ack_req_d;
    logic        bth_valid_q, bth_valid_d;
    logic        reth_valid_q, reth_valid_d;
    logic        err_early_q, err_early_d;
    logic        err_zero_q, err_zero_d;

    // Header of the packet about to start: from the new command in IDLE,
    // otherwise from what is left after the current packet.
    logic [31:0] hdr_rem;
    logic        hdr_first;
    logic        hdr_final;
    logic [12:0] hdr_len;

    logic        in_payload;
    logic        beat;
    logic        pkt_end;
    logic        cmd_end;
    logic        early_last;
    logic        unused_tkeep;

    assign unused_tkeep = ^s_axis_tkeep;

    assign in_payload = (state_q == ST_PAYLOAD);
    assign beat       = in_payload && s_axis_tvalid && m_roce_payload_axis_tready;
    assign pkt_end    = (pkt_left_q <= 13'd8);
    assign cmd_end    = pkt_end && (remaining_q == {19'b0, pkt_len_q});
    assign early_last = in_payload && s_axis_tlast && !cmd_end;

    assign hdr_first = (state_q == ST_IDLE);
    assign hdr_rem   = hdr_first ? s_cmd_length : (remaining_q - {19'b0, pkt_len_q});
    assign hdr_final = (hdr_rem <= PMTU_W);
    assign hdr_len   = hdr_final ? hdr_rem[12:0] : PMTU_W[12:0];

    always_comb begin
        state_d      = state_q;
        v_addr_d     = v_addr_q;
        r_key_d      = r_key_q;
        length_d     = length_q;
        remaining_d  = remaining_q;
        dest_qp_d    = dest_qp_q;
        psn_d        = psn_q;
        p_key_d      = p_key_q;
        udp_length_d = udp_length_q;
        pkt_len_d    = pkt_len_q;
        pkt_left_d   = pkt_left_q;
        op_code_d    = op_code_q;
        ack_req_d    = ack_req_q;
        bth_valid_d  = bth_valid_q;
        reth_valid_d = reth_valid_q;
        err_early_d  = 1'b0;
        err_zero_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_cmd_valid) begin
                    if (s_cmd_length == 32'd0) begin
                        err_zero_d = 1'b1;
                    end else begin
                        v_addr_d    = s_cmd_v_addr;
                        r_key_d     = s_cmd_r_key;
                        length_d    = s_cmd_length;
                        dest_qp_d   = s_cmd_dest_qp;
                        p_key_d     = s_cmd_p_key;
                        psn_d       = s_cmd_psn;
                        remaining_d = s_cmd_length;
                        state_d     = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                bth_valid_d  = bth_valid_q && !m_roce_bth_ready;
                reth_valid_d = reth_valid_q && !m_roce_reth_ready;
                if (!bth_valid_d && !reth_valid_d) begin
                    pkt_left_d = pkt_len_q;
                    state_d    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (beat) begin
                    if (early_last) begin
                        err_early_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (pkt_end) begin
                        remaining_d = hdr_rem;
                        psn_d       = psn_q + 24'd1;
                        if (cmd_end) begin
                            err_early_d = !s_axis_tlast;
                            state_d     = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else begin
                        pkt_left_d = pkt_left_q - 13'd8;
                    end
                end
            end
            ST_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every transition into HDR loads a fresh, stable header.
        if (state_d == ST_HDR && state_q != ST_HDR) begin
            pkt_len_d    = hdr_len;
            ack_req_d    = hdr_final;
            op_code_d    = hdr_first ? (hdr_final ? 8'h0A : 8'h06)
                                     : (hdr_final ? 8'h08 : 8'h07);
            udp_length_d = 16'd24 + (hdr_first ? 16'd16 : 16'd0) + {3'b0, hdr_len};
            bth_valid_d  = 1'b1;
            reth_valid_d = hdr_first;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            v_addr_q     <= '0;
            r_key_q      <= '0;
            length_q     <= '0;
            remaining_q  <= '0;
            dest_qp_q    <= '0;
            psn_q        <= '0;
            p_key_q      <= '0;
            udp_length_q <= '0;
            pkt_len_q    <= '0;
            pkt_left_q   <= '0;
            op_code_q    <= '0;
            ack_req_q    <= 1'b0;
            bth_valid_q  <= 1'b0;
            reth_valid_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_addr_q     <= v_addr_d;
            r_key_q      <= r_key_d;
            length_q     <= length_d;
            remaining_q  <= remaining_d;
            dest_qp_q    <= dest_qp_d;
            psn_q        <= psn_d;
            p_key_q      <= p_key_d;
            udp_length_q <= udp_length_d;
            pkt_len_q    <= pkt_len_d;
            pkt_left_q   <= pkt_left_d;
            op_code_q    <= op_code_d;
            ack_req_q    <= ack_req_d;
            bth_valid_q  <= bth_valid_d;
            reth_valid_q <= reth_valid_d;
            err_early_q  <= err_early_d;
            err_zero_q   <= err_zero_d;
        end
    end

    assign s_cmd_ready   = (state_q == ST_IDLE);
    assign s_axis_tready = in_payload ? m_roce_payload_axis_tready : (state_q == ST_DRAIN);
    assign busy          = (state_q != ST_IDLE);

    assign m_roce_bth_valid   = bth_valid_q;
    assign m_roce_bth_op_code = op_code_q;
    assign m_roce_bth_p_key   = p_key_q;
    assign m_roce_bth_psn     = psn_q;
    assign m_roce_bth_dest_qp = dest_qp_q;
    assign m_roce_bth_ack_req = ack_req_q;
    assign m_udp_length       = udp_length_q;

    assign m_roce_reth_valid  = reth_valid_q;
    assign m_roce_reth_v_addr = v_addr_q;
    assign m_roce_reth_r_key  = r_key_q;
    assign m_roce_reth_length = length_q;

    // Payload is a zero-latency passthrough; keep is rebuilt from the byte count.
    assign m_roce_payload_axis_tvalid = in_payload && s_axis_tvalid;
    assign m_roce_payload_axis_tdata  = in_payload ? s_axis_tdata : '0;
    assign m_roce_payload_axis_tkeep  = !in_payload ? 8'h00 :
                                        (pkt_left_q >= 13'd8) ? 8'hFF :
                                        (8'hFF >> (4'd8 - {1'b0, pkt_left_q[2:0]}));
    assign m_roce_payload_axis_tlast  = in_payload && (pkt_end || s_axis_tlast);
    assign m_roce_payload_axis_tuser  = early_last;

    assign error_early_termination = err_early_q;
    assign error_zero_length       = err_zero_q;

endmodule

// File: tb/tb_roce_write_segmenter_64.sv
module tb_roce_write_segmenter_64;

    localparam int PMTU = 1024;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_cmd_valid, s_cmd_ready;
    logic [31:0] s_cmd_length, s_cmd_r_key;
    logic [63:0] s_cmd_v_addr;
    logic [23:0] s_cmd_dest_qp, s_cmd_psn;
    logic [15:0] s_cmd_p_key;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic        m_roce_bth_valid, m_roce_bth_ready;
    logic [7:0]  m_roce_bth_op_code;
    logic [15:0] m_roce_bth_p_key;
    logic [23:0] m_roce_bth_psn, m_roce_bth_dest_qp;
    logic        m_roce_bth_ack_req;
    logic        m_roce_reth_valid, m_roce_reth_ready;
    logic [63:0] m_roce_reth_v_addr;
    logic [31:0] m_roce_reth_r_key, m_roce_reth_length;
    logic [15:0] m_udp_length;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic        busy, error_early_termination, error_zero_length;

    always #5 clk = ~clk;

    roce_write_segmenter_64 #(.PMTU(PMTU)) dut (
        .clk                        (clk),
        .resetn                     (resetn),
        .s_cmd_valid                (s_cmd_valid),
        .s_cmd_ready                (s_cmd_ready),
        .s_cmd_length               (s_cmd_length),
        .s_cmd_v_addr               (s_cmd_v_addr),
        .s_cmd_r_key                (s_cmd_r_key),
        .s_cmd_dest_qp              (s_cmd_dest_qp),
        .s_cmd_psn                  (s_cmd_psn),
        .s_cmd_p_key                (s_cmd_p_key),
        .s_axis_tdata               (s_axis_tdata),
        .s_axis_tkeep               (s_axis_tkeep),
        .s_axis_tvalid              (s_axis_tvalid),
        .s_axis_tready              (s_axis_tready),
        .s_axis_tlast               (s_axis_tlast),
        .m_roce_bth_valid           (m_roce_bth_valid),
        .m_roce_bth_ready           (m_roce_bth_ready),
        .m_roce_bth_op_code         (m_roce_bth_op_code),
        .m_roce_bth_p_key           (m_roce_bth_p_key),
        .m_roce_bth_psn             (m_roce_bth_psn),
        .m_roce_bth_dest_qp         (m_roce_bth_dest_qp),
        .m_roce_bth_ack_req         (m_roce_bth_ack_req),
        .m_roce_reth_valid          (m_roce_reth_valid),
        .m_roce_reth_ready          (m_roce_reth_ready),
        .m_roce_reth_v_addr         (m_roce_reth_v_addr),
        .m_roce_reth_r_key          (m_roce_reth_r_key),
        .m_roce_reth_length         (m_roce_reth_length),
        .m_udp_length               (m_udp_length),
        .m_roce_payload_axis_tdata  (m_tdata),
        .m_roce_payload_axis_tkeep  (m_tkeep),
        .m_roce_payload_axis_tvalid (m_tvalid),
        .m_roce_payload_axis_tready (m_tready),
        .m_roce_payload_axis_tlast  (m_tlast),
        .m_roce_payload_axis_tuser  (m_tuser),
        .busy                       (busy),
        .error_early_termination    (error_early_termination),
        .error_zero_length          (error_zero_length)
    );

    typedef struct {
        logic [7:0]  op;
        logic [23:0] psn;
        logic        ack;
        logic [15:0] udp;
    } hdr_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write command: n_in input beats, tlast on the last of them.
    task automatic run_cmd(input int len, input logic [23:0] psn0, input int n_in,
                           input bit stall, input string name);
        hdr_t        eh[$];
        beat_t       eb[$];
        logic [63:0] din[$];
        logic [63:0] va;
        logic [31:0] rk;
        logic [23:0] qp;
        logic [15:0] pk;
        int          nb_cmd, n_fwd, last_pkt, exp_err;
        bit          early, done;
        int          in_idx, bth_i, reth_i, beat_i, err_cnt, zero_cnt;
        logic [191:0] bth_vec, reth_vec, prev_bth_vec, prev_reth_vec;
        bit          prev_bth_stall, prev_reth_stall;

        va = {$urandom, $urandom};
        rk = $urandom;
        qp = 24'($urandom);
        pk = 16'($urandom);

        // Reference model: packets and beats from plain byte arithmetic.
        nb_cmd  = (len + 7) / 8;
        early   = (n_in < nb_cmd);
        n_fwd   = early ? n_in : nb_cmd;
        exp_err = (n_in != nb_cmd) ? 1 : 0;
        for (int i = 0; i < n_in; i++) din.push_back({$urandom, $urandom});
        last_pkt = (8 * (n_fwd - 1)) / PMTU;
        for (int k = 0; k <= last_pkt; k++) begin
            hdr_t h;
            int   left, plen;
            left  = len - k * PMTU;
            plen  = (left < PMTU) ? left : PMTU;
            h.op  = (k == 0) ? ((left <= PMTU) ? 8'h0A : 8'h06)
                             : ((left <= PMTU) ? 8'h08 : 8'h07);
            h.ack = (left <= PMTU);
            h.udp = 16'(8 + 12 + ((k == 0) ? 16 : 0) + plen + 4);
            h.psn = 24'(psn0 + 24'(k));
            eh.push_back(h);
        end
        for (int i = 0; i < n_fwd; i++) begin
            beat_t b;
            int    bytes;
            bit    pend, ehere;
            bytes  = (len - 8 * i < 8) ? (len - 8 * i) : 8;
            pend   = (((8 * i + 8) % PMTU) == 0) || (8 * i + 8 >= len);
            ehere  = early && (i == n_fwd - 1);
            b.data = din[i];
            b.keep = 8'((1 << bytes) - 1);
            b.last = pend || ehere;
            b.user = ehere;
            eb.push_back(b);
        end

        s_cmd_valid   = 1'b1;
        s_cmd_length  = 32'(len);
        s_cmd_v_addr  = va;
        s_cmd_r_key   = rk;
        s_cmd_dest_qp = qp;
        s_cmd_psn     = psn0;
        s_cmd_p_key   = pk;
        #1;
        check({name, ":cmd_ready"}, s_cmd_ready, 1'b1);
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;

        in_idx = 0; bth_i = 0; reth_i = 0; beat_i = 0; err_cnt = 0; zero_cnt = 0;
        done = 1'b0; prev_bth_stall = 1'b0; prev_reth_stall = 1'b0;
        prev_bth_vec = '0; prev_reth_vec = '0;
        for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
            m_roce_bth_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_roce_reth_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready          = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid     = (in_idx < n_in) && (!stall || ($urandom_range(0, 3) != 0));
            s_axis_tdata      = (in_idx < n_in) ? din[in_idx] : 64'h0;
            s_axis_tlast      = (in_idx == n_in - 1);
            #1;
            if (cyc == 0) check({name, ":busy"}, busy, 1'b1);
            if (error_early_termination) err_cnt++;
            if (error_zero_length) zero_cnt++;

            bth_vec  = {m_roce_bth_valid, m_roce_bth_op_code, m_roce_bth_psn, m_roce_bth_ack_req,
                        m_udp_length, m_roce_bth_p_key, m_roce_bth_dest_qp};
            reth_vec = {m_roce_reth_valid, m_roce_reth_v_addr, m_roce_reth_r_key, m_roce_reth_length};
            if (prev_bth_stall)  check({name, ":bth_stable"}, bth_vec, prev_bth_vec);
            if (prev_reth_stall) check({name, ":reth_stable"}, reth_vec, prev_reth_vec);
            prev_bth_stall  = m_roce_bth_valid && !m_roce_bth_ready;
            prev_reth_stall = m_roce_reth_valid && !m_roce_reth_ready;
            prev_bth_vec    = bth_vec;
            prev_reth_vec   = reth_vec;

            if (m_roce_bth_valid && m_roce_bth_ready) begin
                if (bth_i < eh.size()) begin
                    check({name, ":op_code"}, m_roce_bth_op_code, eh[bth_i].op);
                    check({name, ":psn"}, m_roce_bth_psn, eh[bth_i].psn);
                    check({name, ":ack_req"}, m_roce_bth_ack_req, eh[bth_i].ack);
                    check({name, ":udp_length"}, m_udp_length, eh[bth_i].udp);
                    check({name, ":p_key"}, m_roce_bth_p_key, pk);
                    check({name, ":dest_qp"}, m_roce_bth_dest_qp, qp);
                end
                bth_i++;
            end
            if (m_roce_reth_valid && m_roce_reth_ready) begin
                if (reth_i == 0) begin
                    check({name, ":reth_v_addr"}, m_roce_reth_v_addr, va);
                    check({name, ":reth_r_key"}, m_roce_reth_r_key, rk);
                    check({name, ":reth_length"}, m_roce_reth_length, 32'(len));
                end
                reth_i++;
            end
            if (m_tvalid && m_tready) begin
                if (beat_i < eb.size()) begin
                    check({name, ":tdata"}, m_tdata, eb[beat_i].data);
                    check({name, ":tkeep"}, m_tkeep, eb[beat_i].keep);
                    check({name, ":tlast"}, m_tlast, eb[beat_i].last);
                    check({name, ":tuser"}, m_tuser, eb[beat_i].user);
                end
                beat_i++;
            end
            if (s_axis_tvalid && s_axis_tready) in_idx++;
            if (in_idx == n_in && busy === 1'b0 && cyc > 0) done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge clk); #1;
        if (error_early_termination) err_cnt++;

        check({name, ":completed_in_budget"}, done, 1'b1);
        check({name, ":bth_count"}, bth_i, eh.size());
        check({name, ":reth_count"}, reth_i, 1);
        check({name, ":beat_count"}, beat_i, eb.size());
        check({name, ":input_consumed"}, in_idx, n_in);
        check({name, ":early_err_pulses"}, err_cnt, exp_err);
        check({name, ":zero_err_pulses"}, zero_cnt, 0);
        check({name, ":busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int len, nb, mode, n_in;

        resetn = 1'b0;
        s_cmd_valid = 1'b0; s_cmd_length = '0; s_cmd_v_addr = '0; s_cmd_r_key = '0;
        s_cmd_dest_qp = '0; s_cmd_psn = '0; s_cmd_p_key = '0;
        s_axis_tdata = '0; s_axis_tkeep = 8'hFF; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_roce_bth_ready = 1'b1; m_roce_reth_ready = 1'b1; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:cmd_ready", s_cmd_ready, 1'b1);
        check("rst:axis_tready", s_axis_tready, 1'b0);
        check("rst:busy", busy, 1'b0);
        check("rst:bth_valid", m_roce_bth_valid, 1'b0);
        check("rst:reth_valid", m_roce_reth_valid, 1'b0);
        check("rst:m_tvalid", m_tvalid, 1'b0);
        check("rst:udp_length", m_udp_length, 16'h0);
        check("rst:errors", {error_early_termination, error_zero_length}, 2'b00);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_cmd(64,   24'd200,    8,   1'b0, "only64");
        run_cmd(2500, 24'd200,    313, 1'b0, "fml2500");
        run_cmd(2048, 24'hFFFFFF, 256, 1'b0, "psn_wrap");
        run_cmd(64,   24'd10,     4,   1'b0, "early_tlast");
        run_cmd(64,   24'd11,     8,   1'b0, "after_early");
        run_cmd(16,   24'd12,     5,   1'b0, "drain");

        // Zero-length command is rejected with a single pulse and no header.
        s_cmd_valid = 1'b1; s_cmd_length = 32'd0;
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        check("zero:err_pulse", error_zero_length, 1'b1);
        check("zero:busy", busy, 1'b0);
        check("zero:bth_valid", m_roce_bth_valid, 1'b0);
        @(posedge clk); #1;
        check("zero:err_pulse_end", error_zero_length, 1'b0);

        run_cmd(2500, 24'd300, 313, 1'b1, "stall2500");

        // Reset while a header is pending aborts straight back to idle.
        m_roce_bth_ready = 1'b0;
        s_cmd_valid = 1'b1; s_cmd_length = 32'd64;
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("abort:bth_pending", m_roce_bth_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check("abort:busy", busy, 1'b0);
        check("abort:bth_valid", m_roce_bth_valid, 1'b0);
        check("abort:cmd_ready", s_cmd_ready, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) begin
            len  = $urandom_range(1, 3500);
            nb   = (len + 7) / 8;
            mode = $urandom_range(0, 2);
            if (mode == 0)      n_in = nb;
            else if (mode == 1) n_in = $urandom_range(1, nb);
            else                n_in = nb + $urandom_range(1, 4);
            run_cmd(len, 24'($urandom), n_in, 1'b1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/roce_write_segmenter_64.md
Name: roce_write_segmenter_64

Overview:
- Upstream stage of the RoCE UDP transmitter.
- Accepts one RDMA WRITE command plus a 64-bit AXI-Stream payload, and splits it into PMTU-sized RC packets.
- For each packet it emits BTH fields, RETH fields (FIRST/ONLY only), the UDP length, and the payload beats, which feed the RoCE UDP TX 64 header/payload inputs directly.

Parameters:
- PMTU, 1024, payload bytes per packet; power of two, 256..4096, multiple of 8.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_cmd_valid / s_cmd_ready  in/out  1  command handshake
- s_cmd_length  in  32  total write bytes
- s_cmd_v_addr  in  64  remote virtual address
- s_cmd_r_key  in  32  remote key
- s_cmd_dest_qp  in  24  destination QP
- s_cmd_psn  in  24  PSN of first packet
- s_cmd_p_key  in  16  partition key
- s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  64/8/1/1/1  payload in; tkeep is ignored
- m_roce_bth_valid / m_roce_bth_ready  out/in  1  BTH handshake
- m_roce_bth_op_code  out  8  opcode
- m_roce_bth_p_key  out  16  partition key
- m_roce_bth_psn  out  24  packet PSN
- m_roce_bth_dest_qp  out  24  destination QP
- m_roce_bth_ack_req  out  1  ack request
- m_roce_reth_valid / m_roce_reth_ready  out/in  1  RETH handshake
- m_roce_reth_v_addr  out  64  RETH virtual address
- m_roce_reth_r_key  out  32  RETH remote key
- m_roce_reth_length  out  32  RETH length
- m_udp_length  out  16  UDP length; valid with BTH
- m_roce_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  64/8/1/1/1/1  payload out
- busy  out  1  high outside IDLE
- error_early_termination  out  1  one-cycle pulse
- error_zero_length  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE; all valids 0; s_cmd_ready 1; s_axis_tready 0; every other output 0; error pulses 0; busy 0.
- Reset asserted mid-packet aborts immediately. No tlast is produced.
- State IDLE:
  - s_cmd_ready=1. On accept, latch all command fields; remaining=length; psn=s_cmd_psn.
  - length==0: pulse error_zero_length, stay in IDLE, emit nothing.
  - Otherwise go to HDR.
- State HDR: registered header outputs, held stable until accepted.
  - pkt_len = min(remaining, PMTU).
  - First packet: ONLY (0x0A) if remaining<=PMTU, else FIRST (0x06).
  - Later packets: LAST (0x08) if remaining<=PMTU, else MIDDLE (0x07).
  - ack_req=1 for LAST/ONLY only.
  - RETH valid for FIRST/ONLY only: v_addr=cmd v_addr, r_key, length=cmd length.
  - m_udp_length = 8 + 12 + (16 if RETH) + pkt_len + 4 (ICRC), 16-bit.
  - BTH and RETH valids rise together and drop independently on their own handshake.
  - Go to PAYLOAD once every asserted valid has completed.
- State PAYLOAD: zero-latency passthrough.
  - s_axis_tready = m_tready; m_tvalid = s_tvalid; tdata passes through.
  - Per beat: bytes = min(8, pkt bytes left); tkeep = low-aligned mask of bytes; tuser=0.
  - m_tlast when the packet's byte count is exhausted.
  - At packet end: remaining -= pkt_len; psn = psn+1 mod 2^24 (FFFFFF wraps to 000000).
  - Then go to HDR if remaining>0, else IDLE.
- Early input tlast (before the command length is exhausted):
  - Output tlast on that beat with tuser=1.
  - Pulse error_early_termination; go to IDLE.
- Input tlast missing when the command completes: enter DRAIN.
  - DRAIN: s_axis_tready=1, beats discarded, m_tvalid=0.
  - Pulse error_early_termination on entry; return to IDLE on the input tlast beat.
- Input tlast coinciding with the final command byte is normal completion.
- Backpressure on any output stalls without data loss or duplication.
- Header outputs are stable while valid && !ready.
- s_cmd_ready=0 outside IDLE.

Test Plan:
- PMTU=1024, length=64, psn=200 -> one ONLY 0x0A, psn 200, ack_req 1, RETH length 64, udp_length 104; 8 beats, last tkeep 0xFF with tlast; busy low after.
- length=2500 ->
  - FIRST: psn 200, udp_length 1064, RETH valid.
  - MIDDLE: psn 201, udp_length 1048, no RETH.
  - LAST: psn 202, udp_length 476, 57 beats, final tkeep 0x0F, ack_req only on LAST.
- psn=0xFFFFFF, length=2048 -> FIRST psn FFFFFF, LAST psn 000000.
- length=64, input tlast on beat 4 -> output tlast+tuser on beat 4, error_early_termination one pulse, IDLE; next command processed normally.
- length=16, input tlast on beat 5 -> 2 beats forwarded, 3 beats dropped, error pulse, IDLE after beat 5.
- length=0 -> error_zero_length pulse, no BTH; plus random m_tready/bth_ready/reth_ready toggling during a 2500-byte write -> beat-exact data match, headers stable while stalled.
